// File: rtl/wdpm_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package wdpm_pkg;

  localparam int unsigned PM_AW_DEF = 5;
  localparam int unsigned IW_DEF    = 16;

  // Instruction opcodes (bits [15:12] of an instruction word)
  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_XOR = 4'h4,
    OP_SHL = 4'h5,
    OP_SHR = 4'h6,
    OP_LDI = 4'h7,
    OP_LD  = 4'h8,
    OP_ST  = 4'h9,
    OP_NOP = 4'hA,
    OP_BEQ = 4'hB,
    OP_BNE = 4'hC,
    OP_IN  = 4'hD,
    OP_OUT = 4'hE,
    OP_JMP = 4'hF
  } op_code_t;

  typedef struct packed {
    op_code_t    op;
    logic [11:0] arg;
  } instr_t;

  // Default NOP_W: opcode NOP, all other fields zero (16'hA000)
  localparam logic [IW_DEF-1:0] NOP_WORD = {OP_NOP, 12'h000};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/prog_mem.sv
// Program memory: one synchronous write port, one synchronous read port with read enable.
module prog_mem #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 16
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Array write; contents survive reset
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read register; holds its word while re_i is low. No reset: consumers qualify it.
  always_ff @(posedge clk_i) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: program counter, fetch FSM, IR register and program-load gating.
module instr_fetch
  import wdpm_pkg::*;
#(
  parameter int unsigned   PM_AW = PM_AW_DEF,
  parameter int unsigned   IW    = IW_DEF,
  parameter logic [IW-1:0] NOP_W = IW'(NOP_WORD)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LD_EN,
  input  logic [PM_AW-1:0] LD_ADDR,
  input  logic [IW-1:0]    LD_DATA,
  output logic             LD_ERR,
  input  logic             START,
  input  logic             HALT,
  input  logic             STALL,
  input  logic             JMP,
  input  logic [PM_AW-1:0] JMP_ADDR,
  output logic [IW-1:0]    IR_OUT,
  output logic             IR_VALID,
  output logic [PM_AW-1:0] PC_OUT,
  output logic             BUSY
);

  fetch_state_t     state_q, state_d;
  logic [PM_AW-1:0] pc_q, pc_d;          // next address to read
  logic [PM_AW-1:0] rd_addr_q, rd_addr_d; // address of the word in the read register
  logic             rd_vld_q, rd_vld_d;   // read register holds a real fetch
  logic [IW-1:0]    ir_q, ir_d;
  logic             ir_vld_q, ir_vld_d;
  logic [PM_AW-1:0] pc_out_q, pc_out_d;
  logic             ld_err_q, ld_err_d;
  logic             busy_q, busy_d;

  logic             mem_we_c;
  logic             mem_re_c;
  logic [PM_AW-1:0] mem_raddr_c;
  logic [IW-1:0]    mem_rdata;

  prog_mem #(
    .AW (PM_AW),
    .DW (IW)
  ) u_prog_mem (
    .clk_i   (CLK),
    .we_i    (mem_we_c),
    .waddr_i (LD_ADDR),
    .wdata_i (LD_DATA),
    .re_i    (mem_re_c),
    .raddr_i (mem_raddr_c),
    .rdata_o (mem_rdata)
  );

  // Next-state: FSM, PC mux, IR update, memory read control and load gating
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    rd_addr_d   = rd_addr_q;
    rd_vld_d    = rd_vld_q;
    ir_d        = ir_q;
    ir_vld_d    = ir_vld_q;
    pc_out_d    = pc_out_q;
    mem_re_c    = 1'b0;
    mem_raddr_c = pc_q;
    mem_we_c    = LD_EN && (state_q == IDLE);
    ld_err_d    = LD_EN && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (START) begin
          state_d  = FILL;
          pc_d     = '0;
          rd_vld_d = 1'b0;
        end
      end
      default: begin
        if (HALT) begin
          state_d  = IDLE;
          pc_d     = '0;
          rd_vld_d = 1'b0;
          ir_d     = NOP_W;
          ir_vld_d = 1'b0;
          pc_out_d = '0;
        end else if (!STALL) begin
          // Retire the word sitting in the read register into IR
          ir_d     = rd_vld_q ? mem_rdata : NOP_W;
          ir_vld_d = rd_vld_q;
          if (rd_vld_q) pc_out_d = rd_addr_q;
          mem_re_c = 1'b1;
          rd_vld_d = 1'b1;
          if ((state_q == RUN) && JMP && ir_vld_q) begin
            // Squash the sequential word and fetch the target instead
            mem_raddr_c = JMP_ADDR;
            rd_addr_d   = JMP_ADDR;
            pc_d        = JMP_ADDR + PM_AW'(1);
            ir_d        = NOP_W;
            ir_vld_d    = 1'b0;
            pc_out_d    = pc_out_q;
            state_d     = FLUSH;
          end else begin
            mem_raddr_c = pc_q;
            rd_addr_d   = pc_q;
            pc_d        = pc_q + PM_AW'(1);
            state_d     = RUN;
          end
        end
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      rd_addr_q <= '0;
      rd_vld_q  <= 1'b0;
      ir_q      <= NOP_W;
      ir_vld_q  <= 1'b0;
      pc_out_q  <= '0;
      ld_err_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      rd_addr_q <= rd_addr_d;
      rd_vld_q  <= rd_vld_d;
      ir_q      <= ir_d;
      ir_vld_q  <= ir_vld_d;
      pc_out_q  <= pc_out_d;
      ld_err_q  <= ld_err_d;
      busy_q    <= busy_d;
    end
  end

  assign IR_OUT   = ir_q;
  assign IR_VALID = ir_vld_q;
  assign PC_OUT   = pc_out_q;
  assign LD_ERR   = ld_err_q;
  assign BUSY     = busy_q;

endmodule
